egress_interface_depacketizer: RTL

EGRESS_INTERFACE_DEPACKETIZER -- requirements
Module: egress_interface_depacketizer

---
 rtl/egress_interface_depacketizer_pkg.sv | 17 +
 rtl/egress_interface_depacketizer_fifo.sv | 65 ++++++
 rtl/egress_interface_depacketizer.sv | 84 ++++++++
 3 files changed

// File: rtl/egress_interface_depacketizer_pkg.sv
// Shared packet-header field layout and address-match helper for the egress depacketizer.
// Field offsets are relative to the first header bit, which sits directly above the payload.
package egress_interface_depacketizer_pkg;

    localparam int DEST_WIDTH = 12;
    localparam int TAG_WIDTH  = 4;
    localparam int DEST_OFS   = 0;
    localparam int TAG_OFS    = DEST_OFS + DEST_WIDTH;

    localparam logic [DEST_WIDTH-1:0] BROADCAST_ADDR = 12'hFFF;

    function automatic logic addr_match(input logic [DEST_WIDTH-1:0] dest,
                                        input logic [DEST_WIDTH-1:0] local_addr);
        return (dest == local_addr) || (dest == BROADCAST_ADDR);
    endfunction

endpackage

// File: rtl/egress_interface_depacketizer_fifo.sv
// depacketizer_fifo: power-of-two circular buffer with a combinational head read.
// The count is one bit wider than the pointers so full and empty stay distinguishable.
module depacketizer_fifo
    import egress_interface_depacketizer_pkg::*;
#(
    parameter int WIDTH = 132,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while the count covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/egress_interface_depacketizer.sv
// Strips the header from addressed packets and buffers payload+tag for the egress consumer.
// Define DEPACKETIZER_DROP_COUNT_EN to build the saturating mismatch drop counter.
module egress_interface_depacketizer
    import egress_interface_depacketizer_pkg::*;
#(
    parameter int C_PACKET_PAYLOAD_WIDTH = 128,
    parameter int C_PACKET_HEADER_WIDTH  = 16,
    parameter int C_PACKET_WIDTH         = C_PACKET_PAYLOAD_WIDTH + C_PACKET_HEADER_WIDTH,
    parameter int C_FIFO_DEPTH           = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [11:0]                       local_addr,
    input  logic                              ingress_valid,
    output logic                              ingress_ready,
    input  logic [C_PACKET_WIDTH-1:0]         ingress_data,
    output logic                              egress_valid,
    input  logic                              egress_ready,
    output logic [C_PACKET_PAYLOAD_WIDTH-1:0] egress_data,
    output logic [3:0]                        egress_tag,
    output logic [15:0]                       drop_count
);

    localparam int HDR_LSB  = C_PACKET_WIDTH - C_PACKET_HEADER_WIDTH;
    localparam int DEST_LSB = HDR_LSB + DEST_OFS;
    localparam int TAG_LSB  = HDR_LSB + TAG_OFS;
    localparam int ENTRY_W  = C_PACKET_PAYLOAD_WIDTH + TAG_WIDTH;

    logic [DEST_WIDTH-1:0] pkt_dest;
    logic [TAG_WIDTH-1:0]  pkt_tag;
    logic                  accept;
    logic                  match;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    fifo_head;

    assign pkt_dest  = ingress_data[DEST_LSB +: DEST_WIDTH];
    assign pkt_tag   = ingress_data[TAG_LSB +: TAG_WIDTH];
    assign match     = addr_match(pkt_dest, local_addr);
    assign accept    = ingress_valid & ingress_ready;
    assign fifo_push = accept & match;
    assign fifo_pop  = egress_valid & egress_ready;

    // Ready is a pure function of occupancy, so a pop while full cannot reopen it this cycle.
    assign ingress_ready = ~fifo_full;
    assign egress_valid  = ~fifo_empty;
    assign egress_data   = fifo_empty ? '0 : fifo_head[C_PACKET_PAYLOAD_WIDTH-1:0];
    assign egress_tag    = fifo_empty ? '0 : fifo_head[C_PACKET_PAYLOAD_WIDTH +: TAG_WIDTH];

    depacketizer_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data ({pkt_tag, ingress_data[C_PACKET_PAYLOAD_WIDTH-1:0]}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef DEPACKETIZER_DROP_COUNT_EN
    logic [15:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if (accept && !match && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) drop_count_q <= '0;
        else      drop_count_q <= drop_count_d;
    end

    assign drop_count = drop_count_q;
`else
    assign drop_count = '0;
`endif

endmodule
